regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 126 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter: one-cycle ALU results and a small
// in-order FIFO of long-latency results, with a pending-write scoreboard.
module regfile_wb_ctrl #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lr_valid,
   output logic        lr_ready,
   input  logic [4:0]  lr_rd,
   input  logic [31:0] lr_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic        RegWrite,
   output logic [4:0]  addD,
   output logic [31:0] WB_out,
   output logic [31:0] pending,
   output logic        stall_alu
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_n;
   logic [SW-1:0] starve;
   logic [SW-1:0] starve_n;

   logic          alu_grant;
   logic          pop;
   logic          push;
   logic [4:0]    head_rd;
   logic [31:0]   head_data;
   logic [31:0]   set_mask;
   logic [31:0]   clr_mask;
   logic [31:0]   pending_n;

   assign lr_ready  = (count < CW'(DEPTH));
   assign push      = lr_valid && lr_ready;
   assign alu_grant = alu_valid && (alu_rd != 5'd0);
   assign pop       = !alu_grant && (count != '0);
   assign head_rd   = fifo_rd[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   always_comb begin
      count_n = count;
      unique case ({push, pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   // Counts cycles the FIFO waits behind the ALU; any drain resets it.
   always_comb begin
      starve_n = starve;
      if (pop || count == '0)
         starve_n = '0;
      else if (alu_grant && starve != SW'(STARVE_MAX))
         starve_n = starve + 1'b1;
   end

   // A re-issue to the same rd on the pop edge keeps the bit set.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (iss_valid && iss_rd != 5'd0)
         set_mask[iss_rd] = 1'b1;
      if (pop && head_rd != 5'd0)
         clr_mask[head_rd] = 1'b1;
      pending_n    = (pending & ~clr_mask) | set_mask;
      pending_n[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWrite  <= 1'b0;
         addD      <= '0;
         WB_out    <= '0;
         pending   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         starve    <= '0;
         stall_alu <= 1'b0;
      end else begin
         count     <= count_n;
         starve    <= starve_n;
         stall_alu <= (starve_n == SW'(STARVE_MAX));
         pending   <= pending_n;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (alu_grant) begin
            RegWrite <= 1'b1;
            addD     <= alu_rd;
            WB_out   <= alu_data;
         end else if (pop && head_rd != 5'd0) begin
            RegWrite <= 1'b1;
            addD     <= head_rd;
            WB_out   <= head_data;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= lr_rd;
         fifo_data[wr_ptr] <= lr_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: vector table plus multi-cycle
// sequences for FIFO-full starvation, scoreboard race and mid-drain reset.
module tb_regfile_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lr_valid;
   logic        lr_ready;
   logic [4:0]  lr_rd;
   logic [31:0] lr_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic        RegWrite;
   logic [4:0]  addD;
   logic [31:0] WB_out;
   logic [31:0] pending;
   logic        stall_alu;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl #(.DEPTH(2), .STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lr_valid  (lr_valid),
      .lr_ready  (lr_ready),
      .lr_rd     (lr_rd),
      .lr_data   (lr_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .RegWrite  (RegWrite),
      .addD      (addD),
      .WB_out    (WB_out),
      .pending   (pending),
      .stall_alu (stall_alu)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic        iv;
      logic [4:0]  ird;
      logic        rw;
      logic [4:0]  add;
      logic [31:0] wb;
      logic [31:0] pend;
      logic        rdy;
   } vec_t;

   vec_t vec [11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard,
                        input logic [31:0] adat, input logic lv,
                        input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic iv, input logic [4:0] ird);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adat;
      lr_valid  = lv;
      lr_rd     = lrd;
      lr_data   = ldat;
      iss_valid = iv;
      iss_rd    = ird;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic rw,
                          input logic [4:0] add, input logic [31:0] wb);
      chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(rw));
      if (rw) begin
         chk({tag, ".addD"}, 32'(addD), 32'(add));
         chk({tag, ".WB_out"}, WB_out, wb);
      end
   endtask

   initial begin
      vec[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                  1, 5, 32'hDEADBEEF, 32'h0, 1};
      vec[1]  = '{1, 0, 32'h1111, 0, 0, 0, 0, 0,
                  0, 5, 32'hDEADBEEF, 32'h0, 1};
      vec[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 5, 32'hDEADBEEF, 32'h0, 1};
      vec[3]  = '{0, 0, 0, 0, 0, 0, 1, 7,
                  0, 5, 32'hDEADBEEF, 32'h80, 1};
      vec[4]  = '{0, 0, 0, 1, 7, 32'h1234, 0, 0,
                  0, 5, 32'hDEADBEEF, 32'h80, 1};
      vec[5]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                  1, 7, 32'h1234, 32'h0, 1};
      vec[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 7, 32'h1234, 32'h0, 1};
      vec[7]  = '{0, 0, 0, 1, 0, 32'h5555, 0, 0,
                  0, 7, 32'h1234, 32'h0, 1};
      vec[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,
                  0, 7, 32'h1234, 32'h0, 1};
      vec[9]  = '{1, 3, 32'hA, 1, 4, 32'hB, 1, 4,
                  1, 3, 32'hA, 32'h10, 1};
      vec[10] = '{1, 0, 32'h77, 0, 0, 0, 0, 0,
                  1, 4, 32'hB, 32'h0, 1};

      // Reset state
      idle();
      rst_n = 1'b0;
      #3;
      chk("rst.RegWrite", 32'(RegWrite), 0);
      chk("rst.addD", 32'(addD), 0);
      chk("rst.WB_out", WB_out, 0);
      chk("rst.pending", pending, 0);
      chk("rst.lr_ready", 32'(lr_ready), 1);
      chk("rst.stall_alu", 32'(stall_alu), 0);
      #9;
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table
      for (int i = 0; i < 11; i++) begin
         drive(vec[i].av, vec[i].ard, vec[i].adat, vec[i].lv,
               vec[i].lrd, vec[i].ldat, vec[i].iv, vec[i].ird);
         step();
         chk($sformatf("v%0d.RegWrite", i), 32'(RegWrite), 32'(vec[i].rw));
         chk($sformatf("v%0d.addD", i), 32'(addD), 32'(vec[i].add));
         chk($sformatf("v%0d.WB_out", i), WB_out, vec[i].wb);
         chk($sformatf("v%0d.pending", i), pending, vec[i].pend);
         chk($sformatf("v%0d.lr_ready", i), 32'(lr_ready), 32'(vec[i].rdy));
         chk($sformatf("v%0d.stall", i), 32'(stall_alu), 0);
      end

      // FIFO full under continuous ALU traffic, then drain
      do_reset();
      drive(1, 1, 1, 1, 10, 32'hA0, 0, 0);
      step();
      chk_out("full.c0", 1, 1, 1);
      chk("full.c0.rdy", 32'(lr_ready), 1);
      drive(1, 2, 2, 1, 11, 32'hA1, 0, 0);
      step();
      chk("full.c1.rdy", 32'(lr_ready), 0);
      for (int c = 2; c <= 5; c++) begin
         drive(1, 5'(c + 1), 32'(c + 1), 1, 12, 32'hA2, 0, 0);
         #1;
         chk($sformatf("full.c%0d.rdy_pre", c), 32'(lr_ready), 0);
         step();
         chk_out($sformatf("full.c%0d", c), 1, 5'(c + 1), 32'(c + 1));
         chk($sformatf("full.c%0d.stall", c), 32'(stall_alu),
             (c >= 4) ? 32'd1 : 32'd0);
      end
      drive(0, 0, 0, 1, 12, 32'hA2, 0, 0);
      step();
      chk_out("drain.0", 1, 10, 32'hA0);
      chk("drain.0.stall", 32'(stall_alu), 0);
      chk("drain.0.rdy", 32'(lr_ready), 1);
      step();
      chk_out("drain.1", 1, 11, 32'hA1);
      idle();
      step();
      chk_out("drain.2", 1, 12, 32'hA2);
      chk("drain.2.rdy", 32'(lr_ready), 1);
      step();
      chk("drain.3.RegWrite", 32'(RegWrite), 0);

      // Scoreboard set/clear race on x9
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 9);
      step();
      chk("race.issue", pending, 32'h200);
      drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
      step();
      chk("race.push", pending, 32'h200);
      drive(0, 0, 0, 0, 0, 0, 1, 9);
      step();
      chk_out("race.pop", 1, 9, 32'h99);
      chk("race.set_wins", pending, 32'h200);
      drive(0, 0, 0, 1, 9, 32'h98, 0, 0);
      step();
      idle();
      step();
      chk_out("race.pop2", 1, 9, 32'h98);
      chk("race.cleared", pending, 32'h0);

      // Reset while FIFO holds two entries
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 7);
      step();
      drive(0, 0, 0, 0, 0, 0, 1, 8);
      step();
      drive(1, 1, 32'h11, 1, 7, 32'h70, 0, 0);
      step();
      drive(1, 2, 32'h22, 1, 8, 32'h80, 0, 0);
      step();
      chk("mid.pending", pending, 32'h180);
      chk("mid.rdy", 32'(lr_ready), 0);
      chk_out("mid.alu", 1, 2, 32'h22);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid.rst.RegWrite", 32'(RegWrite), 0);
      chk("mid.rst.addD", 32'(addD), 0);
      chk("mid.rst.WB_out", WB_out, 0);
      chk("mid.rst.pending", pending, 0);
      chk("mid.rst.rdy", 32'(lr_ready), 1);
      chk("mid.rst.stall", 32'(stall_alu), 0);
      #10;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("mid.post%0d.RegWrite", c), 32'(RegWrite), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: sim time %0t exceeded limit", $time);
      $fatal(1, "timeout");
   end

endmodule
